rmii_rx_ctrl: RTL
=================

Name: rmii_rx_ctrl

Overview:
Receive-side sequencer for the RMII Ethernet path. It strips the preamble and SFD from the 2-bit RMII stream and forwards payload dibits downstream. It also sequences the shared crc32 engine: reset before each frame, feed the dibits, sample the residue after the frame ends. It then issues a one-cycle frame verdict (good / CRC error / runt / oversize) that upper layers use to commit or discard the buffered frame.

Parameters:
PRE_MIN, 4, minimum count of 2'b01 preamble dibits required before SFD is accepted
MIN_DIBITS, 256, minimum post-SFD dibits, FCS included (64 bytes)
MAX_DIBITS, 6072, maximum post-SFD dibits (1518 bytes)
CRC_LAT, 2, cycles from last crc_valid until crc_residue is final
CRC_RESIDUE, 32'h38FB2284, expected crc32 residue over frame+FCS
CNT_W, 13, width of internal dibit counter (must hold MAX_DIBITS)

Ports:
clk  input  1  system clock (50 MHz RMII reference)
rst  input  1  asynchronous, active-low reset
crsdv  input  1  RMII carrier-sense/data-valid
rxd  input  2  RMII receive dibit
axiov  output  1  payload dibit valid
axiod  output  2  payload dibit
crc_rst  output  1  reset to crc32 engine
crc_valid  output  1  crc32 engine input valid
crc_data  output  2  crc32 engine input dibit
crc_residue  input  32  crc32 engine output
frame_done  output  1  one-cycle verdict strobe
frame_ok  output  1  verdict, valid with frame_done
frame_err  output  2  00 ok, 01 CRC, 10 runt, 11 oversize; valid with frame_done

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0 except crc_rst=1; counters cleared. Reset is honoured mid-frame with no verdict issued.
- States: IDLE, PREAMBLE, DATA, CHECK, DROP.
- IDLE: crc_rst=1. On crsdv=1 and rxd=2'b01, go to PREAMBLE with pre_cnt=1.
- PREAMBLE: crc_rst=1.
  - crsdv=0: go to IDLE silently.
  - rxd=01: pre_cnt++, saturating at PRE_MIN.
  - rxd=11 and pre_cnt>=PRE_MIN: go to DATA, clear dibit_cnt.
  - rxd=11 with pre_cnt<PRE_MIN, or rxd=00/10: go to DROP silently (no verdict).
- DATA: crc_rst=0.
  - Each cycle with crsdv=1: axiov/axiod and crc_valid/crc_data register crsdv/rxd, 1-cycle latency; dibit_cnt++.
  - crsdv=0: go to CHECK with wait_cnt=0; axiov/crc_valid drop on the next cycle.
  - dibit_cnt reaching MAX_DIBITS with crsdv still 1: frame_done=1, frame_err=11, frame_ok=0 the next cycle, then go to DROP. axiov is forced to 0 after the MAX_DIBITS-th dibit.
- CHECK: wait CRC_LAT cycles counted after the last crc_valid, then evaluate for one cycle. Priority: runt (dibit_cnt<MIN_DIBITS, err 10) > CRC mismatch (crc_residue!=CRC_RESIDUE, err 01) > ok (err 00, frame_ok=1). Pulse frame_done, assert crc_rst, go to IDLE. crsdv activity during CHECK is ignored.
- DROP: outputs idle, crc_rst=1; go to IDLE when crsdv=0.
- frame_done is exactly one cycle per DATA-entered frame. frame_ok and frame_err are 0 when frame_done=0.
- dibit_cnt saturates at MAX_DIBITS and never wraps.

Optional Feature:
RMII_RX_STATS_EN
- When defined, adds outputs good_cnt[15:0], crc_err_cnt[15:0] and len_err_cnt[15:0].
  - len_err_cnt counts runt and oversize together.
  - Each counter saturates at 16'hFFFF, increments on its frame_done, and clears on reset.
  - Add input stats_clr (1 bit), synchronous; it clears all three counters, and an increment in the same cycle is lost.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- 28×01, 11, valid 64-byte frame with correct FCS (256 dibits) -> 256 axiov dibits matching input; frame_done once, frame_ok=1, err=00, CRC_LAT+1 cycles after crsdv falls.
- Same frame with one payload bit flipped -> frame_done, frame_ok=0, err=01.
- 28×01, 11, 40 dibits -> err=10, even though the CRC is correct.
- 6100 post-SFD dibits -> frame_done with err=11 after dibit 6072; no further axiov; return to IDLE only after crsdv=0.
- 2×01 then 11, or preamble containing 10 -> no axiov, no frame_done, DROP until crsdv=0, then the next valid frame is accepted.
- rst asserted mid-DATA -> all outputs 0 immediately, no frame_done. With RMII_RX_STATS_EN: counters read 0 after reset, and 3 good frames give good_cnt=3.

Source files
------------

// File: rtl/rmii_rx_ctrl_if.sv
// rmii_rx_ctrl_if: RMII receive stream, payload output, crc32 engine hookup
// and frame verdict for rmii_rx_ctrl.
// With RMII_RX_STATS_EN defined, it also carries the frame statistics
// counters and their clear strobe.
interface rmii_rx_ctrl_if;
    logic        crsdv;
    logic [1:0]  rxd;
    logic        axiov;
    logic [1:0]  axiod;
    logic        crc_rst;
    logic        crc_valid;
    logic [1:0]  crc_data;
    logic [31:0] crc_residue;
    logic        frame_done;
    logic        frame_ok;
    logic [1:0]  frame_err;
`ifdef RMII_RX_STATS_EN
    logic        stats_clr;
    logic [15:0] good_cnt;
    logic [15:0] crc_err_cnt;
    logic [15:0] len_err_cnt;

    modport master (input  crsdv, rxd, crc_residue, stats_clr,
                    output axiov, axiod, crc_rst, crc_valid, crc_data,
                           frame_done, frame_ok, frame_err,
                           good_cnt, crc_err_cnt, len_err_cnt);
    modport slave  (output crsdv, rxd, crc_residue, stats_clr,
                    input  axiov, axiod, crc_rst, crc_valid, crc_data,
                           frame_done, frame_ok, frame_err,
                           good_cnt, crc_err_cnt, len_err_cnt);
`else
    modport master (input  crsdv, rxd, crc_residue,
                    output axiov, axiod, crc_rst, crc_valid, crc_data,
                           frame_done, frame_ok, frame_err);
    modport slave  (output crsdv, rxd, crc_residue,
                    input  axiov, axiod, crc_rst, crc_valid, crc_data,
                           frame_done, frame_ok, frame_err);
`endif
endinterface

// File: rtl/rmii_rx_ctrl.sv
// rmii_rx_ctrl: RMII receive sequencer. It strips the preamble and SFD,
// forwards payload dibits, sequences the shared crc32 engine and issues a
// one-cycle good / CRC / runt / oversize verdict per frame.
// Optional feature macro: RMII_RX_STATS_EN adds saturating frame counters.
module rmii_rx_ctrl #(
    parameter int          PRE_MIN     = 4,
    parameter int          MIN_DIBITS  = 256,
    parameter int          MAX_DIBITS  = 6072,
    parameter int          CRC_LAT     = 2,
    parameter logic [31:0] CRC_RESIDUE = 32'h38FB2284,
    parameter int          CNT_W       = 13
) (
    input  logic           clk,
    input  logic           rst,
    rmii_rx_ctrl_if.master bus
);
    localparam int PRE_W  = $clog2(PRE_MIN + 1);
    localparam int WAIT_W = (CRC_LAT > 1) ? $clog2(CRC_LAT) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DROP  = 3'd4;

    logic [2:0]        state;
    logic [PRE_W-1:0]  pre_cnt;
    logic [CNT_W-1:0]  dibit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              axiov_q, crc_valid_q, done_q, ok_q;
    logic [1:0]        axiod_q, crc_data_q, err_q;

    // Frame sequencer; all data/verdict outputs are one-cycle registered pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pre_cnt     <= '0;
            dibit_cnt   <= '0;
            wait_cnt    <= '0;
            axiov_q     <= 1'b0;
            axiod_q     <= 2'b00;
            crc_valid_q <= 1'b0;
            crc_data_q  <= 2'b00;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 2'b00;
        end else begin
            axiov_q     <= 1'b0;
            axiod_q     <= 2'b00;
            crc_valid_q <= 1'b0;
            crc_data_q  <= 2'b00;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (bus.crsdv && bus.rxd == 2'b01) begin
                        state   <= S_PRE;
                        pre_cnt <= PRE_W'(1);
                    end
                end
                S_PRE: begin
                    if (!bus.crsdv) begin
                        state <= S_IDLE;
                    end else if (bus.rxd == 2'b01) begin
                        if (pre_cnt < PRE_W'(PRE_MIN))
                            pre_cnt <= pre_cnt + 1'b1;
                    end else if (bus.rxd == 2'b11 && pre_cnt >= PRE_W'(PRE_MIN)) begin
                        state     <= S_DATA;
                        dibit_cnt <= '0;
                    end else begin
                        // short preamble or a corrupt dibit: discard the burst
                        state <= S_DROP;
                    end
                end
                S_DATA: begin
                    if (!bus.crsdv) begin
                        state    <= S_CHECK;
                        wait_cnt <= '0;
                    end else if (dibit_cnt == CNT_W'(MAX_DIBITS)) begin
                        // one dibit past the limit: verdict now, swallow the rest
                        done_q <= 1'b1;
                        err_q  <= 2'b11;
                        state  <= S_DROP;
                    end else begin
                        axiov_q     <= 1'b1;
                        axiod_q     <= bus.rxd;
                        crc_valid_q <= 1'b1;
                        crc_data_q  <= bus.rxd;
                        dibit_cnt   <= dibit_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    // wait_cnt counts cycles after the last crc_valid edge
                    if (wait_cnt == WAIT_W'(CRC_LAT - 1)) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                        if (dibit_cnt < CNT_W'(MIN_DIBITS))
                            err_q <= 2'b10;
                        else if (bus.crc_residue != CRC_RESIDUE)
                            err_q <= 2'b01;
                        else
                            ok_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DROP: begin
                    if (!bus.crsdv)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // crc engine is held in reset whenever no frame is being accumulated or checked
    assign bus.crc_rst    = (state != S_DATA) && (state != S_CHECK);
    assign bus.axiov      = axiov_q;
    assign bus.axiod      = axiod_q;
    assign bus.crc_valid  = crc_valid_q;
    assign bus.crc_data   = crc_data_q;
    assign bus.frame_done = done_q;
    assign bus.frame_ok   = ok_q;
    assign bus.frame_err  = err_q;

`ifdef RMII_RX_STATS_EN
    logic [15:0] good_q, crcerr_q, lenerr_q;

    // Saturating verdict counters; a clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            good_q   <= '0;
            crcerr_q <= '0;
            lenerr_q <= '0;
        end else if (bus.stats_clr) begin
            good_q   <= '0;
            crcerr_q <= '0;
            lenerr_q <= '0;
        end else if (done_q) begin
            if (ok_q && good_q != 16'hFFFF)
                good_q <= good_q + 1'b1;
            if (err_q == 2'b01 && crcerr_q != 16'hFFFF)
                crcerr_q <= crcerr_q + 1'b1;
            if (err_q[1] && lenerr_q != 16'hFFFF)
                lenerr_q <= lenerr_q + 1'b1;
        end
    end

    assign bus.good_cnt    = good_q;
    assign bus.crc_err_cnt = crcerr_q;
    assign bus.len_err_cnt = lenerr_q;
`endif
endmodule
